mxrv_div: RTL and testbench
===========================

Name: mxrv_div

Overview:
- Multi-cycle RV32M divider that sits beside the execute stage, serving DIV, DIVU, REM and REMU.
- Execute issues a request with rs1/rs2 operand values, funct3 and the destination register.
- The divider raises busy_o, which execute consumes as its divider-busy input to suppress writeback.
- The divider later presents the result with rd for a single-cycle writeback.

Parameters:
- DATA_W, 32, operand/result width
- REG_ADDR_W, 5, destination register index width
- CNT_W, 6, iteration counter width; must hold DATA_W

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset; clears all state immediately
- start_i  input  1  request strobe from execute; sampled only in IDLE
- dividend_i  input  DATA_W  rs1 value
- divisor_i  input  DATA_W  rs2 value
- op_i  input  3  funct3: 3'b100 DIV, 3'b101 DIVU, 3'b110 REM, 3'b111 REMU
- rd_i  input  REG_ADDR_W  destination register
- flush_i  input  1  control-unit hold/flush; aborts the operation in progress
- busy_o  output  1  high while the operation is in flight (START, CALC)
- ready_o  output  1  one-cycle strobe: result_o/rd_o valid
- result_o  output  DATA_W  quotient or remainder
- rd_o  output  REG_ADDR_W  latched destination register

Behaviour:
- Reset values:
  - state = IDLE.
  - busy_o = 0, ready_o = 0, result_o = 0, rd_o = 0.
  - Internal registers all 0.
- Request capture:
  - At an edge in IDLE with start_i = 1 and flush_i = 0, latch dividend, divisor, op and rd, then go to START.
  - start_i in any other state is ignored; the request is not queued.
- START (1 cycle):
  - Divisor == 0:
    - Quotient = all ones; remainder = dividend.
    - Go to END.
  - Signed op with dividend == 0x8000_0000 and divisor == 0xFFFF_FFFF:
    - Quotient = 0x8000_0000; remainder = 0.
    - Go to END.
  - Otherwise:
    - Load the magnitudes: for signed ops, two's-complement any negative operand; unsigned ops use operands as-is.
    - Clear the partial remainder and set count = 0.
    - Go to CALC.
- CALC (exactly DATA_W cycles):
  - Restoring shift-subtract, one quotient bit per cycle, MSB first.
  - Each cycle: shift {rem, dividend} left 1; if rem >= divisor, subtract and set the quotient LSB to 1.
  - count increments each cycle; after count == DATA_W-1, go to END.
- END (1 cycle):
  - Apply sign fix for signed ops: quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Drive result_o (quotient for op[1] = 0, remainder for op[1] = 1) and rd_o; ready_o = 1 this cycle only.
  - Return to IDLE.
- Output hold: result_o and rd_o hold their value after END until the next END.
- busy_o:
  - 1 in START and CALC, 0 in IDLE and END.
  - Execute therefore writes back in the ready_o cycle.
- Latency, with the request sampled at edge N:
  - Normal: busy_o high cycles N+1..N+33; ready_o high in cycle N+34.
  - Divide-by-zero and overflow: busy_o high in cycle N+1 only; ready_o high in cycle N+2.
- flush_i:
  - In any non-IDLE state, the next edge goes to IDLE with ready_o = 0; result_o and rd_o are unchanged.
  - flush_i has priority over start_i in IDLE.
- rst_n asserted mid-operation: outputs and state clear asynchronously; no ready_o is produced for the aborted op.
- Back-to-back: start_i may be asserted in the END cycle; it is ignored. A new request is accepted from the following IDLE cycle.

Test Plan:
- DIVU 100 / 7 -> busy_o high 33 cycles, ready_o in cycle N+34, result_o = 14; REMU of the same operands -> 2.
- DIV 0xFFFF_FFF9 (-7) / 2 -> result_o = 0xFFFF_FFFD (-3); REM of the same operands -> 0xFFFF_FFFF (-1); rd_o equals the rd_i issued.
- DIV 1234 / 0 -> ready_o in cycle N+2, result_o = 0xFFFF_FFFF; REM 1234 / 0 -> 1234. DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000; REM of the same operands -> 0.
- Start DIVU 1000 / 3, pulse flush_i at cycle N+10 -> IDLE next edge, no ready_o, result_o keeps its previous value. A new DIVU 9 / 3 then completes with result_o = 3.
- Assert start_i with new operands during CALC -> ignored; the original op's result is delivered unchanged.
- Drop rst_n at cycle N+20 -> busy_o, ready_o and result_o read 0 immediately. After release, DIV 15 / 5 completes with result_o = 3.

Source files
------------

// File: rtl/mxrv_div.sv
// mxrv_div: multi-cycle RV32M divider (DIV, DIVU, REM, REMU) beside execute.
// Restoring shift-subtract, one quotient bit per cycle. Division by zero and
// signed overflow are resolved in START without iterating.
//
// state | meaning
// IDLE  | waiting for a request from execute
// START | classify operands; resolve special cases or load magnitudes
// CALC  | DATA_W shift-subtract iterations
// END   | result_o/rd_o valid, ready_o strobe
module mxrv_div #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [DATA_W-1:0]     dividend_i,
  input  logic [DATA_W-1:0]     divisor_i,
  input  logic [2:0]            op_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic [DATA_W-1:0]     result_o,
  output logic [REG_ADDR_W-1:0] rd_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } state_e;

  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);

  state_e                  state_q;
  logic [2:0]              op_q;
  logic [REG_ADDR_W-1:0]   rd_q;
  // a_q holds the raw dividend until START, then the magnitude that shifts
  // out MSB-first while quotient bits shift in at the LSB.
  logic [DATA_W-1:0]       a_q;
  logic [DATA_W-1:0]       b_q;
  logic [DATA_W-1:0]       rem_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    qneg_q;
  logic                    rneg_q;
  logic                    busy_q;
  logic                    ready_q;
  logic [DATA_W-1:0]       result_q;
  logic [REG_ADDR_W-1:0]   rdo_q;

  logic                    is_signed;
  logic [DATA_W:0]         rem_sh;
  logic [DATA_W:0]         diff;
  logic                    ge;
  logic [DATA_W-1:0]       rem_d;
  logic [DATA_W-1:0]       quo_d;
  logic [DATA_W-1:0]       quo_fix;
  logic [DATA_W-1:0]       rem_fix;

  assign is_signed = ~op_q[0];

  // One restoring step plus the sign fix applied to its outcome on the last step.
  always_comb begin
    rem_sh  = {rem_q, a_q[DATA_W-1]};
    diff    = rem_sh - {1'b0, b_q};
    ge      = (rem_sh >= {1'b0, b_q});
    rem_d   = ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0];
    quo_d   = {a_q[DATA_W-2:0], ge};
    quo_fix = qneg_q ? (~quo_d + 1'b1) : quo_d;
    rem_fix = rneg_q ? (~rem_d + 1'b1) : rem_d;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
      rdo_q    <= '0;
    end else if (flush_i) begin
      // Abort whatever is in flight; result_o/rd_o keep the last delivered value.
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          if (start_i) begin
            a_q     <= dividend_i;
            b_q     <= divisor_i;
            op_q    <= op_i;
            rd_q    <= rd_i;
            busy_q  <= 1'b1;
            state_q <= S_START;
          end
        end
        S_START: begin
          if (b_q == '0) begin
            // Quotient all ones, remainder is the dividend untouched.
            result_q <= op_q[1] ? a_q : '1;
            rdo_q    <= rd_q;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_END;
          end else if (is_signed && (a_q == MIN_NEG) && (b_q == '1)) begin
            result_q <= op_q[1] ? '0 : MIN_NEG;
            rdo_q    <= rd_q;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_END;
          end else begin
            a_q     <= (is_signed && a_q[DATA_W-1]) ? (~a_q + 1'b1) : a_q;
            b_q     <= (is_signed && b_q[DATA_W-1]) ? (~b_q + 1'b1) : b_q;
            qneg_q  <= is_signed & (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
            rneg_q  <= is_signed & a_q[DATA_W-1];
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_CALC;
          end
        end
        S_CALC: begin
          rem_q <= rem_d;
          a_q   <= quo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            result_q <= op_q[1] ? rem_fix : quo_fix;
            rdo_q    <= rd_q;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_END;
          end
        end
        S_END: begin
          // A start_i seen here is dropped; the next request comes from IDLE.
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = busy_q;
  assign ready_o  = ready_q;
  assign result_o = result_q;
  assign rd_o     = rdo_q;

endmodule

// File: tb/tb_mxrv_div.sv
// Directed bench for mxrv_div: latency, results, flush, ignored starts, reset.
module tb_mxrv_div;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [2:0]  op_i;
  logic [4:0]  rd_i;
  logic        flush_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic [4:0]  rd_o;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] last_res;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  mxrv_div dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .op_i       (op_i),
    .rd_i       (rd_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .rd_o       (rd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents a request sampled at the next rising edge (edge N); returns at
  // #1 into cycle N+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    start_i    = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_i       = rd;
    @(posedge clk);
    #1;
    start_i    = 1'b0;
  endtask

  // mode 0: plain; 1: stray start during CALC; 2: stray start in the END cycle.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input int exp_lat, input int mode);
    int k;
    int busy_cnt;
    int ready_at;
    issue(op, a, b, rd);
    k = 1;
    busy_cnt = 0;
    ready_at = 0;
    while (k <= 60 && ready_at == 0) begin
      if (ready_o) begin
        ready_at = k;
        chk({tag, " result"}, result_o, exp_res);
        chk({tag, " rd"}, {27'd0, rd_o}, {27'd0, rd});
        if (mode == 2) begin
          start_i    = 1'b1;
          op_i       = OP_DIVU;
          dividend_i = 32'd77;
          divisor_i  = 32'd1;
          rd_i       = 5'd9;
        end
      end else begin
        if (busy_o) busy_cnt++;
        if (mode == 1 && k == 5) begin
          start_i    = 1'b1;
          op_i       = OP_DIVU;
          dividend_i = 32'd77;
          divisor_i  = 32'd1;
          rd_i       = 5'd9;
        end else begin
          start_i = 1'b0;
        end
        @(posedge clk);
        #1;
        k++;
      end
    end
    chk({tag, " ready cycle"}, ready_at, exp_lat);
    chk({tag, " busy cycles"}, busy_cnt, exp_lat - 1);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk({tag, " ready drop"}, {31'd0, ready_o}, 32'd0);
    chk({tag, " idle after"}, {31'd0, busy_o}, 32'd0);
    chk({tag, " hold"}, result_o, exp_res);
    last_res = exp_res;
  endtask

  initial begin
    int saw_ready;
    rst_n      = 1'b0;
    start_i    = 1'b0;
    flush_i    = 1'b0;
    dividend_i = '0;
    divisor_i  = '0;
    op_i       = '0;
    rd_i       = '0;
    last_res   = '0;
    #22;
    chk("rst busy",   {31'd0, busy_o},  32'd0);
    chk("rst ready",  {31'd0, ready_o}, 32'd0);
    chk("rst result", result_o,         32'd0);
    chk("rst rd",     {27'd0, rd_o},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu 100/7",  OP_DIVU, 32'd100, 32'd7, 5'd1, 32'd14, 34, 0);
    run_op("remu 100/7",  OP_REMU, 32'd100, 32'd7, 5'd2, 32'd2,  34, 0);
    run_op("div -7/2",    OP_DIV,  32'hFFFF_FFF9, 32'd2, 5'd17, 32'hFFFF_FFFD, 34, 0);
    run_op("rem -7/2",    OP_REM,  32'hFFFF_FFF9, 32'd2, 5'd18, 32'hFFFF_FFFF, 34, 0);
    run_op("div 100/-7",  OP_DIV,  32'd100, 32'hFFFF_FFF9, 5'd3, 32'hFFFF_FFF2, 34, 0);
    run_op("rem 100/-7",  OP_REM,  32'd100, 32'hFFFF_FFF9, 5'd4, 32'd2, 34, 0);
    run_op("divu max/16", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 5'd5, 32'h0FFF_FFFF, 34, 0);
    run_op("remu max/16", OP_REMU, 32'hFFFF_FFFF, 32'd16, 5'd6, 32'h0000_000F, 34, 0);
    run_op("div by 0",    OP_DIV,  32'd1234, 32'd0, 5'd7, 32'hFFFF_FFFF, 2, 0);
    run_op("rem by 0",    OP_REM,  32'd1234, 32'd0, 5'd8, 32'd1234, 2, 0);
    run_op("div ovf",     OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 2, 0);
    run_op("rem ovf",     OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 2, 0);
    run_op("divu by 0",   OP_DIVU, 32'd55, 32'd0, 5'd12, 32'hFFFF_FFFF, 2, 0);

    // Flush at cycle N+10: IDLE after the next edge, no ready, result held.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd13);
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    chk("flush busy",   {31'd0, busy_o},  32'd0);
    chk("flush ready",  {31'd0, ready_o}, 32'd0);
    chk("flush result", result_o, last_res);
    saw_ready = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (ready_o) saw_ready = 1;
    end
    chk("flush no ready", saw_ready, 0);
    run_op("divu 9/3",    OP_DIVU, 32'd9, 32'd3, 5'd14, 32'd3, 34, 0);

    run_op("start in calc", OP_DIVU, 32'd50, 32'd5, 5'd3, 32'd10, 34, 1);
    run_op("start in end",  OP_REMU, 32'd50, 32'd7, 5'd19, 32'd1, 34, 2);

    // Asynchronous reset mid-operation.
    issue(OP_DIVU, 32'd1000, 32'd3, 5'd21);
    repeat (19) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst busy",   {31'd0, busy_o},  32'd0);
    chk("arst ready",  {31'd0, ready_o}, 32'd0);
    chk("arst result", result_o,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("div 15/5",  OP_DIV, 32'd15, 32'd5, 5'd22, 32'd3, 34, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
